key_step_gen: RTL and testbench
===============================

KEY_STEP_GEN -- requirements
Module: key_step_gen

Interface
REQ-001 Parameter DB_CYCLES, default 1_000_000, SHALL set the stable cycles required to accept a press or a release (min 2).
REQ-002 Parameter HOLD_CYCLES, default 50_000_000, SHALL set the HELD cycles before auto-repeat starts (min 2).
REQ-003 Parameter REP_CYCLES, default 10_000_000, SHALL set the auto-repeat pulse spacing in cycles (min 2).
REQ-004 CLK  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 iKey  input  1  SHALL be the raw, asynchronous, bouncing push-button, 1 = pressed.
REQ-007 iEn  input  1  SHALL gate oStep only; the FSM runs regardless.
REQ-008 oStep  output  1  SHALL be a registered single-cycle step pulse that drives the downstream counter's clock-enable/step input.
REQ-009 oPressed  output  1  SHALL be the registered debounced key level.
REQ-010 oState  output  3  SHALL expose the FSM state encoding.

Function
REQ-011 iKey SHALL pass through a 2-flop synchronizer (s1, s2); only s2 SHALL feed the FSM.
REQ-012 FSM states SHALL be IDLE=0, PRESS_DB=1, HELD=2, REPEAT=3, RELEASE_DB=4; codes 5-7 SHALL go to IDLE on the next edge.
REQ-013 A single cycle counter cnt, sized for the largest parameter, SHALL be cleared on every state change.
REQ-014 IDLE: s2=1 -> PRESS_DB.
REQ-015 PRESS_DB: s2=0 -> IDLE with no pulse; s2=1 and cnt==DB_CYCLES-1 -> HELD; otherwise cnt+1.
REQ-016 Entry into HELD from PRESS_DB SHALL set oStep=1 on the same edge, for one cycle.
REQ-017 HELD: s2=0 -> RELEASE_DB; else cnt==HOLD_CYCLES-1 -> REPEAT with oStep=1; else cnt+1.
REQ-018 REPEAT: s2=0 -> RELEASE_DB; else cnt==REP_CYCLES-1 -> oStep=1 and cnt=0; else cnt+1.
REQ-019 RELEASE_DB: s2=1 -> HELD with cnt=0 and no pulse (release bounce restarts the hold timer); s2=0 and cnt==DB_CYCLES-1 -> IDLE; else cnt+1.
REQ-020 When s2=0 and a terminal count occur in the same cycle, release SHALL win and no pulse SHALL issue.
REQ-021 oStep SHALL be the generated pulse ANDed with iEn sampled on that edge; oStep SHALL never be high on two consecutive cycles.
REQ-022 oPressed SHALL be 1 exactly while the state is HELD, REPEAT or RELEASE_DB.
REQ-023 Latency: with iKey held high from before edge 1, oStep SHALL be high in the cycle after edge DB_CYCLES+3.

Reset
REQ-024 rst_n=0 SHALL immediately force s1=s2=0, state=IDLE, cnt=0, oStep=0 and oPressed=0, with no clock required.
REQ-025 Reset asserted mid-press or mid-repeat SHALL abort with no pulse; after release, a still-held key SHALL be treated as a new press (full debounce).

Verification
Bench parameters: DB_CYCLES=4, HOLD_CYCLES=10, REP_CYCLES=5, CLK period 200 ns.
REQ-026 Clean press, iKey high for 8 cycles then low, iEn=1 -> one oStep in the cycle after edge 7; oPressed high until the release debounce ends; back to IDLE.
REQ-027 Bounce, iKey toggling every cycle for 10 cycles -> no oStep; oState alternates between IDLE and PRESS_DB only.
REQ-028 Hold 30 cycles -> first oStep after edge 7, second on entry to REPEAT 10 cycles later, then one every 5 cycles until release.
REQ-029 Release bounce, with iKey 0 for 2 cycles then 1 while in HELD -> RELEASE_DB then HELD, no pulse, hold timer restarted.
REQ-030 iEn=0 throughout a press -> oStep stays 0; oPressed and oState behave as with iEn=1.
REQ-031 rst_n pulled low for 1 cycle during REPEAT -> outputs 0 immediately; with the key still held, the next oStep comes DB_CYCLES+3 edges after rst_n rises.

Source files
------------

// File: rtl/key_step_gen.sv
// Debounced push-button step generator: single step on press, auto-repeat
// while held, with the raw key passed through a 2-flop synchronizer.
module key_step_gen #(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int REP_CYCLES  = 10_000_000
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       iKey,
    input  logic       iEn,
    output logic       oStep,
    output logic       oPressed,
    output logic [2:0] oState
);

    localparam int MAX_A   = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYC = (MAX_A > REP_CYCLES) ? MAX_A : REP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC);

    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        HELD       = 3'd2,
        REPEAT     = 3'd3,
        RELEASE_DB = 3'd4
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          s1, s2;
    logic          pulse;

    // Two-flop synchronizer for the asynchronous key input.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= iKey;
            s2 <= s1;
        end
    end

    // Next-state, counter and pulse decode; a release always wins over a
    // terminal count, and every state change clears the counter.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        pulse    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (s2) state_nx = PRESS_DB;
            end
            PRESS_DB: begin
                if (!s2) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                    pulse    = 1'b1;
                end
            end
            HELD: begin
                if (!s2) begin
                    state_nx = RELEASE_DB;
                    cnt_nx   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_nx = REPEAT;
                    cnt_nx   = '0;
                    pulse    = 1'b1;
                end
            end
            REPEAT: begin
                if (!s2) begin
                    state_nx = RELEASE_DB;
                    cnt_nx   = '0;
                end else if (cnt == REP_LAST) begin
                    cnt_nx = '0;
                    pulse  = 1'b1;
                end
            end
            RELEASE_DB: begin
                // A bounce back to pressed returns to HELD and restarts the hold timer.
                if (s2) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            oStep    <= 1'b0;
            oPressed <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            oStep    <= pulse & iEn;
            oPressed <= (state_nx == HELD) || (state_nx == REPEAT) ||
                        (state_nx == RELEASE_DB);
        end
    end

    assign oState = state;

endmodule

// File: tb/tb_key_step_gen.sv
// Self-checking bench for key_step_gen: expected step cycles are queued when a
// press is driven and popped by a monitor as oStep pulses appear.
`timescale 1ns/1ps
module tb_key_step_gen;

    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int REP  = 5;

    logic       CLK   = 1'b0;
    logic       rst_n = 1'b1;
    logic       iKey  = 1'b0;
    logic       iEn   = 1'b1;
    logic       oStep;
    logic       oPressed;
    logic [2:0] oState;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int exp_q[$];
    int mon_e;
    logic prev_step = 1'b0;

    key_step_gen #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REP_CYCLES(REP)) dut (
        .CLK(CLK), .rst_n(rst_n), .iKey(iKey), .iEn(iEn),
        .oStep(oStep), .oPressed(oPressed), .oState(oState)
    );

    always #100 CLK = ~CLK;

    // Cycle index: after edge k of a scenario started at c0, cyc == c0 + k.
    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard monitor: every oStep pulse must match the next expected cycle.
    always @(negedge CLK) begin
        if (oStep) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL step_unexpected: oStep at cycle %0d, required none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc !== mon_e) begin
                    fails++;
                    $display("FAIL step_cycle: oStep at cycle %0d, required %0d", cyc, mon_e);
                end
            end
            tests++;
            if (prev_step) begin
                fails++;
                $display("FAIL step_consecutive: oStep high at cycle %0d and previous, required single", cyc);
            end
        end
        prev_step = oStep;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset();
        #5 rst_n = 1'b0;
        iKey = 1'b1;
        tick(3);
        tests++;
        if (oStep !== 1'b0 || oPressed !== 1'b0 || oState !== 3'd0) begin
            fails++;
            $display("FAIL reset_outputs: step=%b pressed=%b state=%0d, required 0/0/0", oStep, oPressed, oState);
        end
        iKey  = 1'b0;
        rst_n = 1'b1;
        tick(4);
        tests++;
        if (oState !== 3'd0) begin
            fails++;
            $display("FAIL reset_idle: state=%0d, required 0", oState);
        end
    endtask

    task automatic test_clean_press();
        int c0;
        c0 = cyc;
        exp_q.push_back(c0 + DB + 3);
        iKey = 1'b1;
        tick(6);
        tests++;
        if (oState !== 3'd1 || oPressed !== 1'b0) begin
            fails++;
            $display("FAIL clean_predb: state=%0d pressed=%b, required 1/0", oState, oPressed);
        end
        tick(1);
        tests++;
        if (oState !== 3'd2 || oPressed !== 1'b1) begin
            fails++;
            $display("FAIL clean_held: state=%0d pressed=%b, required 2/1", oState, oPressed);
        end
        tick(1);
        iKey = 1'b0;
        tick(6);
        tests++;
        if (oState !== 3'd4 || oPressed !== 1'b1) begin
            fails++;
            $display("FAIL clean_reldb: state=%0d pressed=%b, required 4/1", oState, oPressed);
        end
        tick(1);
        tests++;
        if (oState !== 3'd0 || oPressed !== 1'b0) begin
            fails++;
            $display("FAIL clean_idle: state=%0d pressed=%b, required 0/0", oState, oPressed);
        end
        tick(3);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL clean_missing: %0d steps pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_bounce();
        bit saw_pd;
        saw_pd = 1'b0;
        for (int i = 0; i < 14; i++) begin
            iKey = (i < 10) ? ((i % 2) == 0) : 1'b0;
            tick(1);
            if (oState === 3'd1) saw_pd = 1'b1;
            tests++;
            if (oState !== 3'd0 && oState !== 3'd1) begin
                fails++;
                $display("FAIL bounce_state: cycle %0d state=%0d, required 0 or 1", i, oState);
            end
        end
        tests++;
        if (!saw_pd) begin
            fails++;
            $display("FAIL bounce_predb: PRESS_DB seen=%b, required 1", saw_pd);
        end
    endtask

    // Key held for len cycles: first step at DB+3, then HOLD later, then every
    // REP; the release is seen at edge len+3 and suppresses any step due there.
    task automatic test_hold(input int len, input string name);
        int c0;
        int e;
        c0 = cyc;
        e  = DB + 3;
        if (e < len + 3) exp_q.push_back(c0 + e);
        e += HOLD;
        while (e < len + 3) begin
            exp_q.push_back(c0 + e);
            e += REP;
        end
        iKey = 1'b1;
        tick(len);
        iKey = 1'b0;
        tick(DB + 2);
        tests++;
        if (oState !== 3'd4 || oPressed !== 1'b1) begin
            fails++;
            $display("FAIL %s_reldb: state=%0d pressed=%b, required 4/1", name, oState, oPressed);
        end
        tick(1);
        tests++;
        if (oState !== 3'd0 || oPressed !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle: state=%0d pressed=%b, required 0/0", name, oState, oPressed);
        end
        tick(2);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_missing: %0d steps pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_release_bounce();
        int c0;
        c0 = cyc;
        exp_q.push_back(c0 + 7);
        exp_q.push_back(c0 + 24);
        iKey = 1'b1;
        tick(9);
        iKey = 1'b0;
        tick(2);
        iKey = 1'b1;
        tick(1);
        tests++;
        if (oState !== 3'd4 || oPressed !== 1'b1) begin
            fails++;
            $display("FAIL relb_reldb: state=%0d pressed=%b, required 4/1", oState, oPressed);
        end
        tick(2);
        tests++;
        if (oState !== 3'd2) begin
            fails++;
            $display("FAIL relb_held: state=%0d, required 2", oState);
        end
        tick(3);
        tests++;
        if (oState !== 3'd2) begin
            fails++;
            $display("FAIL relb_restart: state=%0d, required 2", oState);
        end
        tick(8);
        iKey = 1'b0;
        tick(7);
        tests++;
        if (oState !== 3'd0) begin
            fails++;
            $display("FAIL relb_idle: state=%0d, required 0", oState);
        end
        tick(2);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL relb_missing: %0d steps pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_no_enable();
        iEn  = 1'b0;
        iKey = 1'b1;
        tick(7);
        tests++;
        if (oState !== 3'd2 || oPressed !== 1'b1 || oStep !== 1'b0) begin
            fails++;
            $display("FAIL noen_held: state=%0d pressed=%b step=%b, required 2/1/0", oState, oPressed, oStep);
        end
        tick(1);
        iKey = 1'b0;
        tick(6);
        tests++;
        if (oState !== 3'd4 || oPressed !== 1'b1) begin
            fails++;
            $display("FAIL noen_reldb: state=%0d pressed=%b, required 4/1", oState, oPressed);
        end
        tick(1);
        tests++;
        if (oState !== 3'd0 || oPressed !== 1'b0) begin
            fails++;
            $display("FAIL noen_idle: state=%0d pressed=%b, required 0/0", oState, oPressed);
        end
        tick(2);
        iEn = 1'b1;
    endtask

    task automatic test_reset_repeat();
        int c0;
        int c1;
        c0 = cyc;
        exp_q.push_back(c0 + 7);
        exp_q.push_back(c0 + 17);
        iKey = 1'b1;
        tick(22);
        // A repeat step is high right now; reset must kill it without a clock.
        tests++;
        if (oStep !== 1'b1 || oState !== 3'd3) begin
            fails++;
            $display("FAIL rstrep_pre: step=%b state=%0d, required 1/3", oStep, oState);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (oStep !== 1'b0 || oPressed !== 1'b0 || oState !== 3'd0) begin
            fails++;
            $display("FAIL rstrep_async: step=%b pressed=%b state=%0d, required 0/0/0", oStep, oPressed, oState);
        end
        tick(1);
        rst_n = 1'b1;
        c1 = cyc;
        exp_q.push_back(c1 + DB + 3);
        tick(2);
        tests++;
        if (oState !== 3'd0) begin
            fails++;
            $display("FAIL rstrep_sync: state=%0d, required 0", oState);
        end
        tick(1);
        tests++;
        if (oState !== 3'd1) begin
            fails++;
            $display("FAIL rstrep_predb: state=%0d, required 1", oState);
        end
        tick(6);
        iKey = 1'b0;
        tick(8);
        tests++;
        if (oState !== 3'd0 || oPressed !== 1'b0) begin
            fails++;
            $display("FAIL rstrep_idle: state=%0d pressed=%b, required 0/0", oState, oPressed);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL rstrep_missing: %0d steps pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        tick(4);
        test_hold(30, "hold30");
        test_hold(14, "hold_edge");
        test_hold(19, "rep_edge");
        test_release_bounce();
        test_no_enable();
        test_reset_repeat();
        tick(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
